// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC with DEPTH-deep ring->PE and PE->ring FIFOs, status registers and VC-aware injection.
// Optional macro CARDINAL_NIC_VC_SPLIT_EN splits the output buffer into one FIFO per virtual channel.
module cardinal_nic_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    localparam int PW = $clog2(DEPTH);
`ifdef CARDINAL_NIC_VC_SPLIT_EN
    localparam int NQ = 2;
`else
    localparam int NQ = 1;
`endif
    localparam int OCW = $clog2(NQ * DEPTH) + 1;

    logic proc_rd, proc_wr, wr_out;

    assign proc_rd = nicEn && !nicEnWr;
    assign proc_wr = nicEn && nicEnWr;
    assign wr_out  = proc_wr && (addr == 2'b10);

    // ---------------- input FIFO (ring -> PE) ----------------
    logic [0:DATA_WIDTH-1] in_mem [DEPTH];
    logic [PW-1:0]         in_wp, in_rp;
    logic [CNT_W-1:0]      in_cnt;
    logic                  in_full, in_empty, in_push, in_pop;

    assign in_full  = (in_cnt == CNT_W'(DEPTH));
    assign in_empty = (in_cnt == '0);
    assign net_ri   = !in_full;
    // A push is gated by full at the start of the cycle, even if a pop happens on the same edge.
    assign in_push  = net_si && !in_full;
    assign in_pop   = proc_rd && (addr == 2'b00) && !in_empty;

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp] <= net_di;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_wp  <= '0;
            in_rp  <= '0;
            in_cnt <= '0;
        end else begin
            if (in_push) in_wp <= in_wp + 1'b1;
            if (in_pop)  in_rp <= in_rp + 1'b1;
            case ({in_push, in_pop})
                2'b10:   in_cnt <= in_cnt + 1'b1;
                2'b01:   in_cnt <= in_cnt - 1'b1;
                default: in_cnt <= in_cnt;
            endcase
        end
    end

    // ---------------- output FIFO(s) (PE -> ring) ----------------
    logic [0:DATA_WIDTH-1] out_mem  [NQ][DEPTH];
    logic [PW-1:0]         out_wp   [NQ];
    logic [PW-1:0]         out_rp   [NQ];
    logic [CNT_W-1:0]      out_cnt  [NQ];
    logic [0:DATA_WIDTH-1] out_head [NQ];
    logic [NQ-1:0]         full_q, sel_q, elig_q, push_q, pop_q;
    logic [OCW-1:0]        out_count;
    logic                  out_full, inject, overflow, ovf_set, ovf_clr;
    logic [0:DATA_WIDTH-1] inj_data;

    always_comb begin
        out_count = '0;
        inj_data  = '0;
        for (int q = 0; q < NQ; q++) begin
            out_head[q] = out_mem[q][out_rp[q]];
            full_q[q]   = (out_cnt[q] == CNT_W'(DEPTH));
`ifdef CARDINAL_NIC_VC_SPLIT_EN
            // Each FIFO holds one VC, so only the FIFO matching the phase may inject.
            sel_q[q]  = (d_in[0] == 1'(q));
            elig_q[q] = (out_cnt[q] != '0) && (net_polarity == 1'(q));
`else
            sel_q[q]  = 1'b1;
            elig_q[q] = (out_cnt[q] != '0) && (out_head[q][0] == net_polarity);
`endif
            push_q[q] = wr_out && sel_q[q] && !full_q[q];
            pop_q[q]  = net_ro && elig_q[q];
            out_count = out_count + OCW'(out_cnt[q]);
            if (pop_q[q]) inj_data = out_head[q];
        end
        inject   = |pop_q;
        out_full = wr_out ? |(sel_q & full_q) : |full_q;
        ovf_set  = wr_out && |(sel_q & full_q);
        ovf_clr  = proc_rd && (addr == 2'b11);
    end

    always_ff @(posedge clk) begin
        for (int q = 0; q < NQ; q++) begin
            if (push_q[q]) out_mem[q][out_wp[q]] <= d_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int q = 0; q < NQ; q++) begin
                out_wp[q]  <= '0;
                out_rp[q]  <= '0;
                out_cnt[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (push_q[q]) out_wp[q] <= out_wp[q] + 1'b1;
                if (pop_q[q])  out_rp[q] <= out_rp[q] + 1'b1;
                case ({push_q[q], pop_q[q]})
                    2'b10:   out_cnt[q] <= out_cnt[q] + 1'b1;
                    2'b01:   out_cnt[q] <= out_cnt[q] - 1'b1;
                    default: out_cnt[q] <= out_cnt[q];
                endcase
            end
        end
    end

    // A new overflow on the same edge as a status read wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            net_so <= 1'b0;
            net_do <= '0;
        end else begin
            net_so <= inject;
            if (inject) net_do <= inj_data;
        end
    end

    // ---------------- processor read port ----------------
    logic [0:DATA_WIDTH-1] d_out_nxt;

    always_comb begin
        d_out_nxt = '0;
        case (addr)
            2'b00: if (!in_empty) d_out_nxt = in_mem[in_rp];
            2'b01: begin
                d_out_nxt[0]                        = in_full;
                d_out_nxt[DATA_WIDTH-CNT_W +: CNT_W] = in_cnt;
            end
            2'b11: begin
                d_out_nxt[0]                    = out_full;
                d_out_nxt[1]                    = overflow;
                d_out_nxt[DATA_WIDTH-OCW +: OCW] = out_count;
            end
            default: d_out_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        d_out <= '0;
        else if (proc_rd) d_out <= d_out_nxt;
    end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Bench for cardinal_nic_fifo (default build): directed steps plus random traffic against a queue model.
module tb_cardinal_nic_fifo;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [0:1]    addr;
    logic [0:DW-1] d_in, d_out, net_di, net_do;
    logic          nicEn, nicEnWr, net_si, net_ri, net_so, net_ro, net_polarity;

    always #5 clk = ~clk;

    cardinal_nic_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    int nvec  = 0;
    int nfail = 0;

    logic [0:DW-1] in_q[$];
    logic [0:DW-1] out_q[$];
    logic          m_ovf, m_so;
    logic [0:DW-1] m_dout, m_do;

    task automatic check(input string tag, input logic [0:DW-1] got, input logic [0:DW-1] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        in_q.delete();
        out_q.delete();
        m_ovf  = 1'b0;
        m_so   = 1'b0;
        m_dout = '0;
        m_do   = '0;
    endtask

    // Applies the NIC rules to the model using the values present just before the edge.
    task automatic model_edge();
        logic [0:DW-1] nd;
        bit rd, wr, in_full, out_full, in_push, in_pop, out_push, inj;
        rd       = nicEn && !nicEnWr;
        wr       = nicEn && nicEnWr;
        in_full  = (in_q.size() == DEPTH);
        out_full = (out_q.size() == DEPTH);
        in_push  = net_si && !in_full;
        in_pop   = rd && (addr == 2'b00) && (in_q.size() > 0);
        out_push = wr && (addr == 2'b10) && !out_full;
        inj      = (out_q.size() > 0) && net_ro && (out_q[0][0] == net_polarity);
        if (rd) begin
            nd = '0;
            case (addr)
                2'b00: if (in_q.size() > 0) nd = in_q[0];
                2'b01: begin
                    nd[0]          = in_full;
                    nd[DW-CW +: CW] = CW'(in_q.size());
                end
                2'b11: begin
                    nd[0]          = out_full;
                    nd[1]          = m_ovf;
                    nd[DW-CW +: CW] = CW'(out_q.size());
                end
                default: nd = '0;
            endcase
            m_dout = nd;
        end
        if (wr && (addr == 2'b10) && out_full) m_ovf = 1'b1;
        else if (rd && (addr == 2'b11))        m_ovf = 1'b0;
        m_so = inj;
        if (inj) m_do = out_q[0];
        if (in_pop)   void'(in_q.pop_front());
        if (in_push)  in_q.push_back(net_di);
        if (inj)      void'(out_q.pop_front());
        if (out_push) out_q.push_back(d_in);
    endtask

    task automatic step(input bit si, input logic [0:DW-1] di, input bit en, input bit wr,
                        input logic [1:0] a, input logic [0:DW-1] din, input bit ro, input bit pol);
        net_si = si; net_di = di; nicEn = en; nicEnWr = wr; addr = a;
        d_in = din; net_ro = ro; net_polarity = pol;
        #1;
        check1("net_ri_pre", net_ri, in_q.size() < DEPTH);
        model_edge();
        @(posedge clk);
        #1;
        check("d_out", d_out, m_dout);
        check1("net_so", net_so, m_so);
        check("net_do", net_do, m_do);
        check1("net_ri", net_ri, in_q.size() < DEPTH);
    endtask

    task automatic rd_reg(input logic [1:0] a, input bit ro, input bit pol);
        step(1'b0, '0, 1'b1, 1'b0, a, '0, ro, pol);
    endtask

    task automatic do_reset();
        net_si = 1'b0; nicEn = 1'b0; nicEnWr = 1'b0; net_ro = 1'b0;
        reset = 1'b1;
        #2;
        check("rst_d_out", d_out, '0);
        check1("rst_net_so", net_so, 1'b0);
        check("rst_net_do", net_do, '0);
        check1("rst_net_ri", net_ri, 1'b1);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [0:DW-1] v0, v1;
        addr = 2'b00; d_in = '0; net_di = '0; nicEn = 1'b0; nicEnWr = 1'b0;
        net_si = 1'b0; net_ro = 1'b0; net_polarity = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // status registers read back as zero after reset
        rd_reg(2'b01, 1'b0, 1'b0);
        check("st01_reset", d_out, '0);
        rd_reg(2'b11, 1'b0, 1'b0);
        check("st11_reset", d_out, '0);

        // fill the input FIFO, then drain it in order
        for (int i = 0; i < 4; i++) step(1'b1, DW'(64'hA0 + i), 1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0);
        check1("ri_full", net_ri, 1'b0);
        rd_reg(2'b01, 1'b0, 1'b0);
        check("st01_full", d_out, 64'h8000_0000_0000_0004);
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'b00, 1'b0, 1'b0);
            check("rd_in_order", d_out, DW'(64'hA0 + i));
        end
        rd_reg(2'b00, 1'b0, 1'b0);
        check("rd_in_empty", d_out, '0);

        // VC-aware injection with toggling polarity
        v0 = 64'h0000_0000_0000_0B00;
        v1 = 64'h8000_0000_0000_0B01;
        step(1'b0, '0, 1'b1, 1'b1, 2'b10, v0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 2'b10, v1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 2'b00, '0, 1'b1, 1'b0);
        check1("inj_vc0_so", net_so, 1'b1);
        check("inj_vc0_do", net_do, v0);
        step(1'b0, '0, 1'b0, 1'b0, 2'b00, '0, 1'b1, 1'b1);
        check1("inj_vc1_so", net_so, 1'b1);
        check("inj_vc1_do", net_do, v1);
        step(1'b0, '0, 1'b0, 1'b0, 2'b00, '0, 1'b1, 1'b0);
        check1("inj_idle_so", net_so, 1'b0);
        check("inj_hold_do", net_do, v1);

        // overflow on a full output FIFO, cleared by the status read
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b1, 2'b10, DW'(64'hC0 + i), 1'b0, 1'b0);
        rd_reg(2'b11, 1'b0, 1'b0);
        check("st11_ovf", d_out, 64'hC000_0000_0000_0004);
        rd_reg(2'b11, 1'b0, 1'b0);
        check("st11_ovf_clr", d_out, 64'h8000_0000_0000_0004);

        // full input FIFO: pop and rejected push on the same edge
        for (int i = 0; i < 4; i++) step(1'b1, DW'(64'hD0 + i), 1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0);
        step(1'b1, 64'hDEAD, 1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0);
        check("full_pop_val", d_out, 64'hD0);
        rd_reg(2'b01, 1'b0, 1'b0);
        check("full_pop_cnt", d_out, 64'h3);

        // reset in the middle of traffic discards everything
        do_reset();
        rd_reg(2'b01, 1'b0, 1'b0);
        check("st01_midrst", d_out, '0);
        rd_reg(2'b11, 1'b0, 1'b0);
        check("st11_midrst", d_out, '0);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            logic [0:DW-1] rdi, rdin;
            rdi  = {$urandom(), $urandom()};
            rdin = {$urandom(), $urandom()};
            if ($urandom_range(0, 299) == 0) do_reset();
            step(1'($urandom_range(0, 1)), rdi, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), rdin, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
